// File: rtl/alu_packet_engine_if.sv
// alu_packet_engine_if
//   Byte-stream bundle between the UART side and alu_packet_engine.
//
//   Handshake: a byte moves on a rising clock edge where its valid and ready
//   are both high. A producer holds data and valid stable until that transfer.
//   A consumer may raise or lower ready at any time.
//
//   Signals
//     rx_data_i  [7:0]  incoming command byte
//     rx_valid_i        incoming byte valid
//     rx_ready_o        engine accepts an incoming byte
//     tx_data_o  [7:0]  outgoing response byte
//     tx_valid_o        outgoing byte valid
//     tx_ready_i        sink accepts an outgoing byte
//     busy_o            packet in progress
//     err_o             one-cycle pulse on a non-zero status byte
//     state_dbg  [2:0]  current parser state, for observation only
//
//   Modports: master = byte source/sink (UART side), slave = engine.
interface alu_packet_engine_if;
   logic [7:0] rx_data_i;
   logic       rx_valid_i;
   logic       rx_ready_o;
   logic [7:0] tx_data_o;
   logic       tx_valid_o;
   logic       tx_ready_i;
   logic       busy_o;
   logic       err_o;
   logic [2:0] state_dbg;

   modport master (
      output rx_data_i, rx_valid_i, tx_ready_i,
      input  rx_ready_o, tx_data_o, tx_valid_o, busy_o, err_o, state_dbg
   );

   modport slave (
      input  rx_data_i, rx_valid_i, tx_ready_i,
      output rx_ready_o, tx_data_o, tx_valid_o, busy_o, err_o, state_dbg
   );
endinterface

// File: rtl/alu_packet_engine.sv
// alu_packet_engine
//   Parses a framed command from a byte stream:
//     opcode, reserved, count[7:0], count[15:8], count operands
//   Each operand is WIDTH_P/8 bytes, sent little-endian.
//   The operands are reduced with add, multiply, xor, unsigned min or unsigned
//   max, all modulo 2^WIDTH_P.
//   The reply is a status byte: 00 ok, 01 bad opcode, 02 bad count.
//   On ok, WIDTH_P/8 result bytes follow, LSB first.
//   A bad frame still has its operand bytes consumed, so the stream stays in
//   sync with the sender.
//
//   Ports
//     clk_i  clock
//     rst_i  asynchronous active-high reset
//     bus    alu_packet_engine_if.slave (rx/tx byte streams, busy, err, state)
module alu_packet_engine #(
   parameter int WIDTH_P        = 32,
   parameter int MAX_OPERANDS_P = 255
) (
   input logic                clk_i,
   input logic                rst_i,
   alu_packet_engine_if.slave bus
);
   localparam int BYTES = WIDTH_P / 8;

   typedef enum logic [2:0] {
      S_OPCODE  = 3'd0,
      S_RSV     = 3'd1,
      S_LEN_LO  = 3'd2,
      S_LEN_HI  = 3'd3,
      S_OPERAND = 3'd4,
      S_DRAIN   = 3'd5,
      S_STATUS  = 3'd6,
      S_DATA    = 3'd7
   } state_t;

   state_t             state_q;
   logic [7:0]         opcode_q;
   logic [7:0]         len_lo_q;
   logic [7:0]         status_q;
   logic [15:0]        left_q;      // operands still to be received
   logic [2:0]         byte_idx_q;  // byte position inside current operand
   logic [3:0]         tx_idx_q;    // result bytes presented so far
   logic [23:0]        drain_q;     // bytes left to discard; wide enough for 65535*8
   logic               first_q;
   logic [WIDTH_P-1:0] shift_q;
   logic [WIDTH_P-1:0] acc_q;
   logic [WIDTH_P-1:0] res_q;

   logic               rx_fire;
   logic               tx_fire;
   logic [15:0]        len;
   logic [7:0]         len_status;
   logic [WIDTH_P-1:0] operand;
   logic [WIDTH_P-1:0] combined;

   assign rx_fire = bus.rx_valid_i & bus.rx_ready_o;
   assign tx_fire = bus.tx_valid_o & bus.tx_ready_i;
   assign len     = {bus.rx_data_i, len_lo_q};
   // New byte enters at the top; after BYTES bytes the first one sits in bits [7:0].
   assign operand = WIDTH_P'({bus.rx_data_i, shift_q} >> 8);
   assign bus.state_dbg = state_q;

   // A bad count takes priority over a bad opcode.
   always_comb begin
      len_status = 8'h00;
      if (len == 16'd0 || 32'(len) > 32'(MAX_OPERANDS_P))
         len_status = 8'h02;
      else if (opcode_q < 8'h10 || opcode_q > 8'h14)
         len_status = 8'h01;
   end

   always_comb begin
      combined = acc_q;
      case (opcode_q)
         8'h10:   combined = acc_q + operand;
         8'h11:   combined = acc_q * operand;
         8'h12:   combined = acc_q ^ operand;
         8'h13:   combined = (operand < acc_q) ? operand : acc_q;
         8'h14:   combined = (operand > acc_q) ? operand : acc_q;
         default: combined = acc_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= S_OPCODE;
         opcode_q       <= '0;
         len_lo_q       <= '0;
         status_q       <= '0;
         left_q         <= '0;
         byte_idx_q     <= '0;
         tx_idx_q       <= '0;
         drain_q        <= '0;
         first_q        <= 1'b0;
         shift_q        <= '0;
         acc_q          <= '0;
         res_q          <= '0;
         bus.rx_ready_o <= 1'b1;
         bus.tx_valid_o <= 1'b0;
         bus.tx_data_o  <= '0;
         bus.busy_o     <= 1'b0;
         bus.err_o      <= 1'b0;
      end else begin
         bus.err_o <= 1'b0;
         case (state_q)
            S_OPCODE: if (rx_fire) begin
               opcode_q   <= bus.rx_data_i;
               bus.busy_o <= 1'b1;
               state_q    <= S_RSV;
            end
            S_RSV: if (rx_fire) state_q <= S_LEN_LO;
            S_LEN_LO: if (rx_fire) begin
               len_lo_q <= bus.rx_data_i;
               state_q  <= S_LEN_HI;
            end
            S_LEN_HI: if (rx_fire) begin
               status_q   <= len_status;
               left_q     <= len;
               byte_idx_q <= '0;
               first_q    <= 1'b1;
               drain_q    <= 24'(len) * 24'(BYTES);
               if (len == 16'd0) begin
                  // Nothing to receive: present the status byte right away.
                  state_q        <= S_STATUS;
                  bus.rx_ready_o <= 1'b0;
                  bus.tx_valid_o <= 1'b1;
                  bus.tx_data_o  <= len_status;
                  bus.err_o      <= 1'b1;
               end else if (len_status != 8'h00) begin
                  state_q <= S_DRAIN;
               end else begin
                  state_q <= S_OPERAND;
               end
            end
            S_OPERAND: if (rx_fire) begin
               shift_q <= operand;
               if (byte_idx_q == 3'(BYTES - 1)) begin
                  byte_idx_q <= '0;
                  first_q    <= 1'b0;
                  acc_q      <= first_q ? operand : combined;
                  left_q     <= left_q - 16'd1;
                  if (left_q == 16'd1) begin
                     state_q        <= S_STATUS;
                     bus.rx_ready_o <= 1'b0;
                     bus.tx_valid_o <= 1'b1;
                     bus.tx_data_o  <= 8'h00;
                  end
               end else begin
                  byte_idx_q <= byte_idx_q + 3'd1;
               end
            end
            S_DRAIN: if (rx_fire) begin
               drain_q <= drain_q - 24'd1;
               if (drain_q == 24'd1) begin
                  state_q        <= S_STATUS;
                  bus.rx_ready_o <= 1'b0;
                  bus.tx_valid_o <= 1'b1;
                  bus.tx_data_o  <= status_q;
                  bus.err_o      <= 1'b1;
               end
            end
            S_STATUS: if (tx_fire) begin
               if (status_q == 8'h00) begin
                  state_q       <= S_DATA;
                  bus.tx_data_o <= acc_q[7:0];
                  res_q         <= acc_q >> 8;
                  tx_idx_q      <= 4'd1;
               end else begin
                  state_q        <= S_OPCODE;
                  bus.tx_valid_o <= 1'b0;
                  bus.busy_o     <= 1'b0;
                  bus.rx_ready_o <= 1'b1;
               end
            end
            S_DATA: if (tx_fire) begin
               if (tx_idx_q == 4'(BYTES)) begin
                  state_q        <= S_OPCODE;
                  bus.tx_valid_o <= 1'b0;
                  bus.busy_o     <= 1'b0;
                  bus.rx_ready_o <= 1'b1;
               end else begin
                  bus.tx_data_o <= res_q[7:0];
                  res_q         <= res_q >> 8;
                  tx_idx_q      <= tx_idx_q + 4'd1;
               end
            end
            default: state_q <= S_OPCODE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_packet_engine.sv
module tb_alu_packet_engine;
   localparam int W    = 32;
   localparam int NB   = W / 8;
   localparam int MAXN = 255;

   typedef logic [W-1:0] word_q_t[$];

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_packet_engine_if bus ();

   alu_packet_engine #(.WIDTH_P(W), .MAX_OPERANDS_P(MAXN)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int err_pulses   = 0;
   logic [7:0] exp_q[$];

   always @(negedge clk) if (!rst && bus.err_o) err_pulses++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard compare ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // All tasks start and end just after a rising edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      logic acc;
      int   waited;
      repeat (gap) begin @(posedge clk); #1; end
      bus.rx_data_i  = b;
      bus.rx_valid_i = 1'b1;
      waited = 0;
      forever begin
         @(negedge clk);
         acc = bus.rx_ready_o;
         @(posedge clk); #1;
         if (acc) break;
         waited++;
         if (waited > 64) begin
            check("rx_accept_timeout", acc, 1);
            break;
         end
      end
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic recv_byte(input int stall, output logic [7:0] b);
      logic [7:0] held;
      int         waited;
      bus.tx_ready_i = 1'b0;
      waited = 0;
      forever begin
         @(negedge clk);
         if (bus.tx_valid_o || waited > 64) break;
         waited++;
      end
      check("tx_valid", bus.tx_valid_o, 1);
      held = bus.tx_data_o;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("tx_hold_valid", bus.tx_valid_o, 1);
         check("tx_hold_data", bus.tx_data_o, held);
      end
      bus.tx_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.tx_ready_i = 1'b0;
      b = held;
   endtask

   // Reference model: status and result from the frame rules, plain arithmetic.
   task automatic model(input logic [7:0] op, input int cnt, input word_q_t ops,
                        output logic [7:0] status);
      logic [W-1:0]    res;
      longint unsigned t;
      longint unsigned modv;
      modv = 64'd1 << W;
      if (cnt == 0 || cnt > MAXN)       status = 8'h02;
      else if (op < 8'h10 || op > 8'h14) status = 8'h01;
      else                               status = 8'h00;
      exp_q.push_back(status);
      if (status == 8'h00) begin
         res = ops[0];
         for (int i = 1; i < cnt; i++) begin
            case (op)
               8'h10: begin t = 64'(res) + 64'(ops[i]); res = W'(t % modv); end
               8'h11: begin t = 64'(res) * 64'(ops[i]); res = W'(t % modv); end
               8'h12: res = res ^ ops[i];
               8'h13: if (ops[i] < res) res = ops[i];
               default: if (ops[i] > res) res = ops[i];
            endcase
         end
         for (int k = 0; k < NB; k++) exp_q.push_back(res[8*k +: 8]);
      end
   endtask

   task automatic run_packet(input string tag, input logic [7:0] op, input int cnt,
                             input word_q_t ops, input int gap_max, input int stall);
      logic [7:0] status;
      logic [7:0] got;
      int         err_before;
      int         nresp;
      model(op, cnt, ops, status);
      nresp = exp_q.size();
      err_before = err_pulses;
      send_byte(op, $urandom_range(0, gap_max));
      check({tag, "_busy_hi"}, bus.busy_o, 1);
      send_byte(8'($urandom_range(0, 255)), $urandom_range(0, gap_max));
      send_byte(cnt[7:0], $urandom_range(0, gap_max));
      send_byte(cnt[15:8], $urandom_range(0, gap_max));
      for (int i = 0; i < cnt; i++)
         for (int k = 0; k < NB; k++)
            send_byte(ops[i][8*k +: 8], $urandom_range(0, gap_max));
      // Status must be presented the cycle right after the last accepted byte.
      check({tag, "_lat_valid"}, bus.tx_valid_o, 1);
      check({tag, "_lat_status"}, bus.tx_data_o, status);
      check({tag, "_lat_err"}, bus.err_o, (status != 8'h00));
      check({tag, "_rx_blocked"}, bus.rx_ready_o, 0);
      for (int i = 0; i < nresp; i++) begin
         recv_byte(stall, got);
         check({tag, "_resp"}, got, exp_q.pop_front());
      end
      check({tag, "_busy_lo"}, bus.busy_o, 0);
      check({tag, "_rx_ready"}, bus.rx_ready_o, 1);
      check({tag, "_tx_idle"}, bus.tx_valid_o, 0);
      check({tag, "_err_count"}, 64'(err_pulses - err_before), (status != 8'h00) ? 1 : 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, bus.rx_ready_o, 1);
      check({tag, "_tx_valid"}, bus.tx_valid_o, 0);
      check({tag, "_tx_data"}, bus.tx_data_o, 0);
      check({tag, "_busy"}, bus.busy_o, 0);
      check({tag, "_err"}, bus.err_o, 0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      word_q_t    ops;
      logic [7:0] op;
      int         cnt;
      bus.rx_data_i  = '0;
      bus.rx_valid_i = 1'b0;
      bus.tx_ready_i = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      ops = {32'd1, 32'd2};
      run_packet("add", 8'h10, 2, ops, 0, 0);

      ops = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
      run_packet("mul5", 8'h11, 5, ops, 0, 0);

      ops = {32'hFFFF_FFFF, 32'd2};
      run_packet("add_wrap", 8'h10, 2, ops, 0, 0);

      ops = {32'h1234_5678, 32'h9ABC_DEF0};
      run_packet("bad_op", 8'h55, 2, ops, 0, 0);

      ops.delete();
      run_packet("count0", 8'h10, 0, ops, 0, 0);

      ops.delete();
      for (int i = 0; i < 256; i++) ops.push_back($urandom);
      run_packet("count256", 8'h10, 256, ops, 0, 0);

      ops = {32'd7, 32'h8000_0000, 32'd3};
      run_packet("max_bp", 8'h14, 3, ops, 3, 5);

      ops = {32'hDEAD_BEEF};
      run_packet("single", 8'h13, 1, ops, 1, 1);

      // Reset in the middle of an add packet, after six operand bytes.
      send_byte(8'h10, 0);
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 0);
      rst = 1'b1;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      ops = {32'd3, 32'd4};
      run_packet("after_reset", 8'h10, 2, ops, 0, 0);

      // Random packets: mostly valid opcodes, some corner operands, some bad opcodes.
      for (int p = 0; p < 14; p++) begin
         op  = (p % 7 == 6) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(16, 20));
         cnt = $urandom_range(1, 5);
         ops.delete();
         for (int i = 0; i < cnt; i++) begin
            case ($urandom_range(0, 5))
               0:       ops.push_back(32'hFFFF_FFFF);
               1:       ops.push_back(32'd0);
               default: ops.push_back($urandom);
            endcase
         end
         run_packet("rand", op, cnt, ops, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
